rotimm_encoder: RTL and testbench
=================================

Name: rotimm_encoder

Overview:
- Iterative encoder, the inverse of the datapath's rotated-immediate decode: given a 32-bit constant, it finds the ARM data-processing immediate encoding {rot[3:0], imm8[7:0]}. The decode side computes value = ROR(imm8, 2*rot).
- Used by the program-load/debug path to check whether a constant is encodable before emitting an instruction.
- Searches rotations sequentially under a start/done handshake.

Parameters:
- ROT_PER_CYCLE, 1, rotations tested per clock. Legal values: 1, 2, 4, 8, 16; any other value is illegal (elaboration error).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when busy=0
- value  input  32  constant to encode; captured on the accepted start edge
- busy  output  1  search in progress
- done  output  1  single-cycle pulse: result valid
- found  output  1  constant is encodable (valid while done=1 and held afterwards)
- imm8  output  8  encoded 8-bit immediate
- rot  output  4  encoded rotation field; the actual rotation is 2*rot
- encoding  output  12  {rot, imm8}, the Instr[11:0] field

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, found=0, imm8=0, rot=0, encoding=0; internal counter k=0. Reset mid-search aborts the search with no done pulse.
- State machine: IDLE -> SEARCH -> DONE -> IDLE.
- IDLE: start=1 at a rising edge:
  - latches value into value_r, sets k=0, moves to SEARCH, busy=1.
  - Outputs from the previous result (found/imm8/rot/encoding) hold until the next DONE.
- SEARCH: each edge tests candidates k .. k+ROT_PER_CYCLE-1.
  - Candidate j matches when ROL(value_r, 2*j)[31:8] == 0. Equivalent: value_r == ROR(ROL(value_r,2*j)[7:0], 2*j).
  - If any candidate matches, the lowest j wins: register found=1, rot=j, imm8=ROL(value_r,2*j)[7:0]; go to DONE.
  - Otherwise k += ROT_PER_CYCLE. If the batch just tested contained j=15 and there was no match: found=0, imm8=0, rot=0; go to DONE.
  - All rotate arithmetic is modulo 32. 2*j fits in 5 bits; there is no 32-bit shift-by-32 case.
- DONE: lasts exactly one cycle.
  - done=1, busy=0.
  - A start in the DONE cycle is accepted the same way as in IDLE, going directly to SEARCH.
  - Otherwise the next state is IDLE.
- start while in SEARCH: ignored. The value input is not re-sampled during a search.
- Latency for ROT_PER_CYCLE=P and winning rotation j:
  - done is high in the cycle after edge number floor(j/P)+2, counting the start edge as edge 1.
  - Equivalently, done is visible ceil((j+1)/P) edges after the start edge.
  - No match: 16/P edges after the start edge.
- Uniqueness: the smallest rot is always reported, e.g. 0x00000000 -> rot=0, imm8=0.
- busy=1 exactly in SEARCH. done and busy are never both 1.

Test Plan:
- P=1: value=0x000000FF, start for one cycle -> done 1 edge after start, found=1, imm8=0xFF, rot=0, encoding=0x0FF.
- P=1: value=0xFF000000 -> done 5 edges after start, found=1, imm8=0xFF, rot=4, encoding=0x4FF.
- P=1: value=0x000003FC -> done 16 edges after start, found=1, imm8=0xFF, rot=15, encoding=0xFFF. Same value with P=4 -> done 4 edges after start, identical result.
- P=1: value=0x00000101 (not encodable) -> done 16 edges after start, found=0, imm8=0, rot=0. Next, value=0xF000000F -> found=1, imm8=0xFF, rot=2 (smallest rotation).
- Handshake:
  - value=0xFF000000 started; at edge 2 pulse start with value=0x000000FF -> ignored; result still rot=4, imm8=0xFF.
  - Assert start in the DONE cycle with value=0x00000000 -> back-to-back search, rot=0, imm8=0, found=1.
- Reset mid-search: start value=0x000003FC, assert reset at edge 6 -> next cycle busy=0, done=0, found=0, encoding=0, and no done pulse afterwards. A following start with 0x000000FF completes normally.

Source files
------------

// File: rtl/rotimm_encoder.sv
// ---------------------------------------------------------------------------
// rotimm_encoder
//   Iterative search for the ARM data-processing immediate encoding of a
//   32-bit constant: finds the smallest rot such that
//   value == ROR(imm8, 2*rot). ROT_PER_CYCLE rotations are tested per clock.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high reset
//   start     in   1   request pulse, accepted in IDLE or DONE
//   value     in  32   constant to encode, captured on the accepted start
//   busy      out  1   search in progress
//   done      out  1   single-cycle pulse, result valid
//   found     out  1   constant is encodable (held until next result)
//   imm8      out  8   encoded immediate
//   rot       out  4   encoded rotation field (rotation = 2*rot)
//   encoding  out 12   {rot, imm8}
// ---------------------------------------------------------------------------
module rotimm_encoder #(
    parameter int ROT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [7:0]  imm8,
    output logic [3:0]  rot,
    output logic [11:0] encoding
);

    generate
        if (!(ROT_PER_CYCLE == 1 || ROT_PER_CYCLE == 2 || ROT_PER_CYCLE == 4 ||
              ROT_PER_CYCLE == 8 || ROT_PER_CYCLE == 16)) begin : g_bad_param
            $error("rotimm_encoder: ROT_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Batch step and the start index of the batch that contains rotation 15.
    localparam logic [3:0] K_STEP = 4'(ROT_PER_CYCLE);
    localparam logic [3:0] K_LAST = 4'(16 - ROT_PER_CYCLE);

    state_t      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  k_q, k_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic [7:0]  imm8_q, imm8_d;
    logic [3:0]  rot_q, rot_d;

    logic        hit_s;
    logic [3:0]  hit_rot_s;
    logic [7:0]  hit_imm_s;
    logic [3:0]  cand_j_s;
    logic [31:0] rolled_s;

    // Rotate left modulo 32; a shift of 0 makes the right part shift by 32 -> 0.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
        rol32 = (x << sh) | (x >> (6'd32 - {1'b0, sh}));
    endfunction

    // Test the current batch; iterating high-to-low leaves the lowest match.
    always_comb begin
        hit_s     = 1'b0;
        hit_rot_s = 4'd0;
        hit_imm_s = 8'd0;
        cand_j_s  = 4'd0;
        rolled_s  = 32'd0;
        for (int i = ROT_PER_CYCLE - 1; i >= 0; i--) begin
            cand_j_s = k_q + 4'(i);
            rolled_s = rol32(value_q, {cand_j_s, 1'b0});
            if (rolled_s[31:8] == 24'd0) begin
                hit_s     = 1'b1;
                hit_rot_s = cand_j_s;
                hit_imm_s = rolled_s[7:0];
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Next-state and next-output logic for IDLE -> SEARCH -> DONE.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        k_d     = k_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        found_d = found_q;
        imm8_d  = imm8_q;
        rot_d   = rot_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SEARCH;
                    value_d = value;
                    k_d     = 4'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                if (hit_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    found_d = 1'b1;
                    rot_d   = hit_rot_s;
                    imm8_d  = hit_imm_s;
                end else if (k_q == K_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    found_d = 1'b0;
                    rot_d   = 4'd0;
                    imm8_d  = 8'd0;
                end else begin
                    k_d     = k_q + K_STEP;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            value_q <= 32'd0;
            k_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            imm8_q  <= 8'd0;
            rot_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            imm8_q  <= imm8_d;
            rot_q   <= rot_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign found    = found_q;
    assign imm8     = imm8_q;
    assign rot      = rot_q;
    assign encoding = {rot_q, imm8_q};

endmodule

// File: tb/tb_rotimm_encoder.sv
// ---------------------------------------------------------------------------
// tb_rotimm_encoder
//   Drives two encoders (1 and 4 rotations per cycle) with shared stimulus and
//   compares latency and results against an arithmetic reference search.
// ---------------------------------------------------------------------------
module tb_rotimm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;

    logic        busy1, done1, found1;
    logic [7:0]  imm81;
    logic [3:0]  rot1;
    logic [11:0] enc1;
    logic        busy4, done4, found4;
    logic [7:0]  imm84;
    logic [3:0]  rot4;
    logic [11:0] enc4;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    rotimm_encoder #(.ROT_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy1), .done(done1), .found(found1),
        .imm8(imm81), .rot(rot1), .encoding(enc1)
    );

    rotimm_encoder #(.ROT_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy4), .done(done4), .found(found4),
        .imm8(imm84), .rot(rot4), .encoding(enc4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rol(input logic [31:0] x, input int n);
        if (n % 32 == 0) return x;
        return (x << (n % 32)) | (x >> (32 - (n % 32)));
    endfunction

    function automatic logic [31:0] ref_ror(input logic [31:0] x, input int n);
        if (n % 32 == 0) return x;
        return (x >> (n % 32)) | (x << (32 - (n % 32)));
    endfunction

    // Reference: smallest r for which ROR(low byte of ROL(v,2r), 2r) rebuilds v.
    task automatic ref_encode(input logic [31:0] v, output logic ef, output int er,
                              output logic [7:0] ei);
        logic [31:0] cand;
        ef = 1'b0;
        er = 0;
        ei = 8'd0;
        for (int r = 0; r < 16; r++) begin
            cand = ref_rol(v, 2 * r) & 32'h0000_00FF;
            if (!ef && ref_ror(cand, 2 * r) == v) begin
                ef = 1'b1;
                er = r;
                ei = cand[7:0];
            end
        end
    endtask

    // Pulse start for one edge; value is scrambled afterwards so capture is checked.
    task automatic launch(input logic [31:0] v);
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = $urandom;
    endtask

    // Wait for both done pulses and compare latency and results.
    task automatic collect(input logic [31:0] v, input int glitch_e, input logic [31:0] gv);
        logic       ef;
        int         er;
        logic [7:0] ei;
        int         lat1, lat4;
        bit         seen1, seen4;
        ref_encode(v, ef, er, ei);
        lat1  = ef ? er + 1 : 16;
        lat4  = ef ? er / 4 + 1 : 4;
        seen1 = 1'b0;
        seen4 = 1'b0;
        for (int e = 1; e <= 20 && !(seen1 && seen4); e++) begin
            if (e == glitch_e) begin
                start = 1'b1;
                value = gv;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            check_eq("busy_done_excl1", {31'd0, busy1 & done1}, 32'd0);
            check_eq("busy_done_excl4", {31'd0, busy4 & done4}, 32'd0);
            if (seen1) begin
                check_eq("done1_pulse", {31'd0, done1}, 32'd0);
            end else if (done1) begin
                seen1 = 1'b1;
                check_eq("lat1", e, lat1);
                check_eq("found1", {31'd0, found1}, {31'd0, ef});
                check_eq("imm8_1", {24'd0, imm81}, {24'd0, ei});
                check_eq("rot1", {28'd0, rot1}, er);
                check_eq("enc1", {20'd0, enc1}, {20'd0, 4'(er), ei});
            end else begin
                check_eq("busy1_search", {31'd0, busy1}, 32'd1);
            end
            if (seen4) begin
                check_eq("done4_pulse", {31'd0, done4}, 32'd0);
            end else if (done4) begin
                seen4 = 1'b1;
                check_eq("lat4", e, lat4);
                check_eq("found4", {31'd0, found4}, {31'd0, ef});
                check_eq("imm8_4", {24'd0, imm84}, {24'd0, ei});
                check_eq("rot4", {28'd0, rot4}, er);
                check_eq("enc4", {20'd0, enc4}, {20'd0, 4'(er), ei});
            end else begin
                check_eq("busy4_search", {31'd0, busy4}, 32'd1);
            end
        end
        check_eq("done1_seen", {31'd0, seen1}, 32'd1);
        check_eq("done4_seen", {31'd0, seen4}, 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_busy1"},  {31'd0, busy1},  32'd0);
        check_eq({tag, "_done1"},  {31'd0, done1},  32'd0);
        check_eq({tag, "_found1"}, {31'd0, found1}, 32'd0);
        check_eq({tag, "_enc1"},   {20'd0, enc1},   32'd0);
        check_eq({tag, "_busy4"},  {31'd0, busy4},  32'd0);
        check_eq({tag, "_done4"},  {31'd0, done4},  32'd0);
        check_eq({tag, "_found4"}, {31'd0, found4}, 32'd0);
        check_eq({tag, "_enc4"},   {20'd0, enc4},   32'd0);
    endtask

    logic [31:0] directed [5] = '{32'h0000_00FF, 32'hFF00_0000, 32'h0000_03FC,
                                  32'h0000_0101, 32'hF000_000F};

    initial begin
        logic [31:0] rv;
        reset = 1'b1;
        start = 1'b0;
        value = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (directed[i]) begin
            launch(directed[i]);
            collect(directed[i], 0, 32'd0);
        end

        // Start while searching is ignored.
        launch(32'hFF00_0000);
        collect(32'hFF00_0000, 1, 32'h0000_00FF);

        // Back-to-back: start in the DONE cycle (both instances finish together).
        launch(32'h0000_00FF);
        collect(32'h0000_00FF, 0, 32'd0);
        launch(32'h0000_0000);
        collect(32'h0000_0000, 0, 32'd0);

        // Reset on edge 6 of a long search.
        launch(32'h0000_03FC);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_cleared("midreset");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("no_done1_after_reset", {31'd0, done1 | busy1}, 32'd0);
            check_eq("no_done4_after_reset", {31'd0, done4 | busy4}, 32'd0);
        end
        launch(32'h0000_00FF);
        collect(32'h0000_00FF, 0, 32'd0);

        // Random constants: half built from a random imm8/rot, half arbitrary.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                rv = ref_ror({24'd0, 8'($urandom)}, 2 * int'($urandom_range(15, 0)));
            end else begin
                rv = $urandom;
            end
            launch(rv);
            collect(rv, 0, 32'd0);
            if ($urandom_range(1, 0) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
